traffic_request_scheduler: RTL and testbench

Front-end request scheduler for the intersection traffic controller. It conditions raw pedestrian buttons, latches bus-detector and car-arrival pulses, and grants at most one bus priority request at a time. It periodically snapshots car counts into the controller with a one-cycle load pulse, and observes the controller's 4-bit state to decide when each request has been served.

---
 rtl/traffic_request_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_traffic_request_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_request_scheduler.sv
// Request front-end for the intersection controller: button debounce, bus arbitration,
// car counting and the snapshot load strobe toward the controller.
module traffic_request_scheduler #(
    parameter int unsigned CPS          = 2,
    parameter int unsigned DEBOUNCE     = 4,
    parameter int unsigned BUS_PASS     = 2 * CPS,
    parameter int unsigned BUS_HOLD_MAX = 40 * CPS
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_btn_ns,
    input  logic       i_btn_ew,
    input  logic       i_bus_det_ns,
    input  logic       i_bus_det_ew,
    input  logic       i_car_ns,
    input  logic       i_car_ew,
    input  logic [3:0] i_state,
    output logic       o_ped_ns,
    output logic       o_ped_ew,
    output logic       o_bus_ns,
    output logic       o_bus_ew,
    output logic [7:0] o_cars_ns,
    output logic [7:0] o_cars_ew,
    output logic       o_load
);

    localparam int unsigned DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int unsigned PASS_W = (BUS_PASS > 1) ? $clog2(BUS_PASS) : 1;
    localparam int unsigned HOLD_W = (BUS_HOLD_MAX > 1) ? $clog2(BUS_HOLD_MAX) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(BUS_PASS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(BUS_HOLD_MAX - 1);

    localparam logic [3:0] ST_BLINK  = 4'd0;
    localparam logic [3:0] ST_NS_PED = 4'd1;
    localparam logic [3:0] ST_NS_G   = 4'd2;
    localparam logic [3:0] ST_NS_R   = 4'd4;
    localparam logic [3:0] ST_EW_PED = 4'd5;
    localparam logic [3:0] ST_EW_G   = 4'd6;
    localparam logic [3:0] ST_EW_R   = 4'd8;

    typedef enum logic [1:0] {StIdle, StGrantNs, StGrantEw} arb_state_e;

    // Index 0 is NS, index 1 is EW for the button paths.
    logic [1:0]      r_sync1, r_sync2;
    logic [DB_W-1:0] r_db_cnt [2];
    logic [1:0]      r_db_acc, r_db_acc_d;
    logic [1:0]      r_ped;

    arb_state_e        r_arb;
    logic              r_pend_ns, r_pend_ew;
    logic              r_ptr_ew;
    logic              r_bus_ns, r_bus_ew;
    logic [PASS_W-1:0] r_pass_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;

    logic [7:0] r_acc_ns, r_acc_ew;
    logic [7:0] r_cars_ns, r_cars_ew;
    logic [3:0] r_prev_state;
    logic       r_load;

    logic       w_blink;
    logic [1:0] w_ped_rise, w_ped_clr;
    logic       w_grant_green, w_release;
    logic       w_load;
    logic [7:0] w_acc_ns_inc, w_acc_ew_inc;

    assign w_blink    = (i_state == ST_BLINK);
    assign w_ped_rise = r_db_acc & ~r_db_acc_d;
    assign w_ped_clr  = {i_state == ST_EW_PED, i_state == ST_NS_PED};

    assign w_grant_green = ((r_arb == StGrantNs) && (i_state == ST_NS_G)) ||
                           ((r_arb == StGrantEw) && (i_state == ST_EW_G));
    // Pass release needs the final green cycle itself, so a grant always sees BUS_PASS greens.
    assign w_release = (r_arb != StIdle) &&
                       ((w_grant_green && (r_pass_cnt == PASS_LAST)) || (r_hold_cnt == HOLD_LAST));

    assign w_load = ((i_state == ST_NS_R) || (i_state == ST_EW_R)) && (i_state != r_prev_state) &&
                    ((r_acc_ns != 8'd0) || (r_acc_ew != 8'd0));

    assign w_acc_ns_inc = (r_acc_ns == 8'hFF) ? 8'hFF : r_acc_ns + 8'd1;
    assign w_acc_ew_inc = (r_acc_ew == 8'hFF) ? 8'hFF : r_acc_ew + 8'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_db_acc   <= '0;
            r_db_acc_d <= '0;
            r_ped      <= '0;
            for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1    <= {i_btn_ew, i_btn_ns};
            r_sync2    <= r_sync1;
            r_db_acc_d <= r_db_acc;
            for (int i = 0; i < 2; i++) begin
                if (!r_sync2[i]) begin
                    r_db_cnt[i] <= '0;
                    r_db_acc[i] <= 1'b0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db_acc[i] <= 1'b1;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
                if (w_blink || w_ped_clr[i]) r_ped[i] <= 1'b0;
                else if (w_ped_rise[i])      r_ped[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_arb      <= StIdle;
            r_pend_ns  <= 1'b0;
            r_pend_ew  <= 1'b0;
            r_ptr_ew   <= 1'b1;
            r_bus_ns   <= 1'b0;
            r_bus_ew   <= 1'b0;
            r_pass_cnt <= '0;
            r_hold_cnt <= '0;
        end else if (w_blink) begin
            r_arb      <= StIdle;
            r_pend_ns  <= 1'b0;
            r_pend_ew  <= 1'b0;
            r_bus_ns   <= 1'b0;
            r_bus_ew   <= 1'b0;
            r_pass_cnt <= '0;
            r_hold_cnt <= '0;
        end else begin
            case (r_arb)
                StIdle: begin
                    r_pend_ns <= r_pend_ns | i_bus_det_ns;
                    r_pend_ew <= r_pend_ew | i_bus_det_ew;
                    // Decision uses already-registered pends; a tie goes opposite the pointer.
                    if (r_pend_ns && (!r_pend_ew || r_ptr_ew)) begin
                        r_arb    <= StGrantNs;
                        r_bus_ns <= 1'b1;
                    end else if (r_pend_ew) begin
                        r_arb    <= StGrantEw;
                        r_bus_ew <= 1'b1;
                    end
                end
                StGrantNs, StGrantEw: begin
                    if (r_arb == StGrantNs) r_pend_ew <= r_pend_ew | i_bus_det_ew;
                    else                    r_pend_ns <= r_pend_ns | i_bus_det_ns;
                    if (w_release) begin
                        if (r_arb == StGrantNs) r_pend_ns <= 1'b0;
                        else                    r_pend_ew <= 1'b0;
                        r_ptr_ew   <= (r_arb == StGrantEw);
                        r_arb      <= StIdle;
                        r_bus_ns   <= 1'b0;
                        r_bus_ew   <= 1'b0;
                        r_pass_cnt <= '0;
                        r_hold_cnt <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                        if (w_grant_green) r_pass_cnt <= r_pass_cnt + 1'b1;
                    end
                end
                default: begin
                    r_arb    <= StIdle;
                    r_bus_ns <= 1'b0;
                    r_bus_ew <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc_ns     <= 8'd0;
            r_acc_ew     <= 8'd0;
            r_cars_ns    <= 8'd0;
            r_cars_ew    <= 8'd0;
            r_prev_state <= 4'd0;
            r_load       <= 1'b0;
        end else begin
            r_prev_state <= i_state;
            r_load       <= w_load;
            if (w_load) begin
                r_cars_ns <= r_acc_ns;
                r_cars_ew <= r_acc_ew;
                // Restart from this cycle's arrival so a pulse on the load edge is kept.
                r_acc_ns  <= {7'd0, i_car_ns};
                r_acc_ew  <= {7'd0, i_car_ew};
            end else begin
                if (i_car_ns) r_acc_ns <= w_acc_ns_inc;
                if (i_car_ew) r_acc_ew <= w_acc_ew_inc;
            end
        end
    end

    assign o_ped_ns  = r_ped[0];
    assign o_ped_ew  = r_ped[1];
    assign o_bus_ns  = r_bus_ns;
    assign o_bus_ew  = r_bus_ew;
    assign o_cars_ns = r_cars_ns;
    assign o_cars_ew = r_cars_ew;
    assign o_load    = r_load;

endmodule

// File: tb/tb_traffic_request_scheduler.sv
// Bench for traffic_request_scheduler: directed scenarios plus random traffic, every cycle
// checked against an event-level reference model.
module tb_traffic_request_scheduler;

    localparam int CPS          = 2;
    localparam int DEBOUNCE     = 4;
    localparam int BUS_PASS     = 2 * CPS;
    localparam int BUS_HOLD_MAX = 40 * CPS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_ns = 0, btn_ew = 0, det_ns = 0, det_ew = 0, car_ns = 0, car_ew = 0;
    logic [3:0] state = 4'd3;
    logic       ped_ns, ped_ew, bus_ns, bus_ew, load;
    logic [7:0] cars_ns, cars_ew;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    bit [7:0] h_ns, h_ew;
    bit       m_ped_ns, m_ped_ew, m_pend_ns, m_pend_ew, m_load;
    int       m_grant, m_last, m_green, m_age;
    int       m_acc_ns, m_acc_ew, m_cars_ns, m_cars_ew, m_prev;
    int       hold_cycles;

    traffic_request_scheduler #(
        .CPS(CPS), .DEBOUNCE(DEBOUNCE), .BUS_PASS(BUS_PASS), .BUS_HOLD_MAX(BUS_HOLD_MAX)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_btn_ns(btn_ns), .i_btn_ew(btn_ew),
        .i_bus_det_ns(det_ns), .i_bus_det_ew(det_ew),
        .i_car_ns(car_ns), .i_car_ew(car_ew),
        .i_state(state),
        .o_ped_ns(ped_ns), .o_ped_ew(ped_ew),
        .o_bus_ns(bus_ns), .o_bus_ew(bus_ew),
        .o_cars_ns(cars_ns), .o_cars_ew(cars_ew),
        .o_load(load)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        h_ns = 0; h_ew = 0;
        m_ped_ns = 0; m_ped_ew = 0; m_pend_ns = 0; m_pend_ew = 0; m_load = 0;
        m_grant = 0; m_last = 2; m_green = 0; m_age = 0;
        m_acc_ns = 0; m_acc_ew = 0; m_cars_ns = 0; m_cars_ew = 0; m_prev = 0;
    endtask

    // One rising edge of the spec-level behaviour, using the inputs held during the cycle.
    task automatic model_edge();
        int  st, g, a, pick;
        bit  set_ns, set_ew, trig;
        st = int'(state);
        // A press is accepted after DEBOUNCE high samples; request appears 2 edges later.
        h_ns = {h_ns[6:0], btn_ns};
        h_ew = {h_ew[6:0], btn_ew};
        set_ns = (&h_ns[6:3]) && !(&h_ns[7:4]);
        set_ew = (&h_ew[6:3]) && !(&h_ew[7:4]);
        if (st == 0 || st == 1) m_ped_ns = 0; else if (set_ns) m_ped_ns = 1;
        if (st == 0 || st == 5) m_ped_ew = 0; else if (set_ew) m_ped_ew = 1;

        trig = (st == 4 || st == 8) && (st != m_prev) && (m_acc_ns != 0 || m_acc_ew != 0);
        m_load = trig;
        if (trig) begin
            m_cars_ns = m_acc_ns; m_cars_ew = m_acc_ew;
            m_acc_ns = int'(car_ns); m_acc_ew = int'(car_ew);
        end else begin
            if (car_ns && m_acc_ns < 255) m_acc_ns++;
            if (car_ew && m_acc_ew < 255) m_acc_ew++;
        end
        m_prev = st;

        if (st == 0) begin
            m_pend_ns = 0; m_pend_ew = 0; m_grant = 0; m_green = 0; m_age = 0;
        end else if (m_grant == 0) begin
            pick = 0;
            if (m_pend_ns && m_pend_ew) pick = (m_last == 2) ? 1 : 2;
            else if (m_pend_ns)         pick = 1;
            else if (m_pend_ew)         pick = 2;
            m_pend_ns |= det_ns;
            m_pend_ew |= det_ew;
            if (pick != 0) begin
                m_grant = pick; m_green = 0; m_age = 0;
            end
        end else begin
            g = ((m_grant == 1 && st == 2) || (m_grant == 2 && st == 6)) ? m_green + 1 : m_green;
            a = m_age + 1;
            if (m_grant == 1) m_pend_ew |= det_ew; else m_pend_ns |= det_ns;
            if (g >= BUS_PASS || a >= BUS_HOLD_MAX) begin
                if (m_grant == 1) m_pend_ns = 0; else m_pend_ew = 0;
                m_last = m_grant; m_grant = 0; m_green = 0; m_age = 0;
            end else begin
                m_green = g; m_age = a;
            end
        end
    endtask

    task automatic check_outputs();
        check_val("ped_ns", ped_ns, m_ped_ns);
        check_val("ped_ew", ped_ew, m_ped_ew);
        check_val("bus_ns", bus_ns, m_grant == 1);
        check_val("bus_ew", bus_ew, m_grant == 2);
        check_val("load", load, m_load);
        check_val("cars_ns", cars_ns, m_cars_ns);
        check_val("cars_ew", cars_ew, m_cars_ew);
        check_val("bus_mutex", bus_ns & bus_ew, 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        btn_ns = 0; btn_ew = 0; det_ns = 0; det_ew = 0; car_ns = 0; car_ew = 0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        reset_dut();
        check_outputs();

        // Button: rises 6 edges after first sample, set once while held, cleared by NS_PED.
        state = 4'd3; btn_ns = 1;
        repeat (6) step();
        check_val("ped_ns_before_debounce", ped_ns, 0);
        step();
        check_val("ped_ns_after_debounce", ped_ns, 1);
        state = 4'd1; step();
        check_val("ped_ns_cleared", ped_ns, 0);
        state = 4'd3; repeat (2) step();
        check_val("ped_ns_hold_no_reset", ped_ns, 0);
        btn_ns = 0;
        btn_ew = 1; repeat (2) step();
        btn_ew = 0; repeat (8) step();
        check_val("ped_ew_glitch", ped_ew, 0);

        // Simultaneous bus pulses: NS first, then EW after NS release.
        reset_dut();
        state = 4'd3; det_ns = 1; det_ew = 1; step();
        det_ns = 0; det_ew = 0; step();
        check_val("tie_grant_ns", bus_ns, 1);
        check_val("tie_wait_ew", bus_ew, 0);
        state = 4'd2; repeat (4) step();
        check_val("ns_released", bus_ns, 0);
        state = 4'd6; step();
        check_val("ew_granted", bus_ew, 1);
        repeat (3) step();
        check_val("ew_still_held", bus_ew, 1);
        step();
        check_val("ew_released", bus_ew, 0);

        // Watchdog: EW grant while NS is green.
        reset_dut();
        state = 4'd2; det_ew = 1; step();
        det_ew = 0;
        hold_cycles = 0;
        repeat (BUS_HOLD_MAX + 10) begin
            step();
            if (bus_ew) hold_cycles++;
        end
        check_val("watchdog_len", hold_cycles, BUS_HOLD_MAX);

        // Car saturation and load restart.
        reset_dut();
        state = 4'd3; car_ns = 1;
        repeat (300) step();
        state = 4'd4; step();
        check_val("sat_load", load, 1);
        check_val("sat_cars_ns", cars_ns, 255);
        check_val("sat_cars_ew", cars_ew, 0);
        car_ns = 0; state = 4'd3; step();
        check_val("load_one_cycle", load, 0);
        state = 4'd4; step();
        check_val("reload", load, 1);
        check_val("kept_arrival", cars_ns, 1);

        // No load with empty accumulators.
        reset_dut();
        state = 4'd3; step();
        state = 4'd8; step();
        check_val("no_load_empty", load, 0);

        // BLINK clears everything, then async reset mid-grant.
        reset_dut();
        state = 4'd3; btn_ns = 1;
        repeat (8) step();
        det_ns = 1; step();
        det_ns = 0; step();
        check_val("pre_blink_bus", bus_ns, 1);
        check_val("pre_blink_ped", ped_ns, 1);
        btn_ns = 0; state = 4'd0; step();
        check_val("blink_ped", ped_ns, 0);
        check_val("blink_bus", bus_ns, 0);
        state = 4'd3; det_ew = 1; car_ew = 1; step();
        det_ew = 0; step();
        check_val("pre_reset_bus", bus_ew, 1);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_val("reset_bus_ew", bus_ew, 0);
        check_outputs();
        idle_inputs();
        state = 4'd4;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1;
        repeat (3) step();

        // Random traffic.
        reset_dut();
        state = 4'd3;
        hold_cycles = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold_cycles == 0) begin
                if ($urandom_range(0, 24) == 0) state = 4'd0;
                else state = 4'($urandom_range(1, 8));
                hold_cycles = $urandom_range(1, 12);
            end
            hold_cycles--;
            if ($urandom_range(0, 7) == 0) btn_ns = ~btn_ns;
            if ($urandom_range(0, 7) == 0) btn_ew = ~btn_ew;
            det_ns = ($urandom_range(0, 15) == 0);
            det_ew = ($urandom_range(0, 15) == 0);
            car_ns = ($urandom_range(0, 2) == 0);
            car_ew = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
